// File: rtl/fmc_adc_trigger_unit_if.sv
// Trigger-unit bus: sample stream, trigger configuration/sources and the merged trigger result.
// master drives the inputs (acquisition core side), slave is the trigger unit.
interface fmc_adc_trigger_unit_if #(
    parameter int unsigned g_num_ch    = 4,
    parameter int unsigned g_dly_width = 32
);
    logic [16*g_num_ch-1:0]  adc_data_i;
    logic                    adc_valid_i;
    logic [16*g_num_ch-1:0]  thres_val_i;
    logic [16*g_num_ch-1:0]  thres_hyst_i;
    logic [g_num_ch-1:0]     ch_pol_i;
    logic                    ext_trig_i;
    logic                    ext_pol_i;
    logic [g_dly_width-1:0]  ext_dly_i;
    logic                    time_trig_i;
    logic                    sw_trig_i;
    logic [g_num_ch+1:0]     trig_en_i;
    logic                    arm_i;
    logic                    trig_o;
    logic [g_num_ch+2:0]     trig_src_o;

    modport master (
        output adc_data_i, adc_valid_i, thres_val_i, thres_hyst_i, ch_pol_i,
        output ext_trig_i, ext_pol_i, ext_dly_i, time_trig_i, sw_trig_i,
        output trig_en_i, arm_i,
        input  trig_o, trig_src_o
    );

    modport slave (
        input  adc_data_i, adc_valid_i, thres_val_i, thres_hyst_i, ch_pol_i,
        input  ext_trig_i, ext_pol_i, ext_dly_i, time_trig_i, sw_trig_i,
        input  trig_en_i, arm_i,
        output trig_o, trig_src_o
    );
endinterface

// File: rtl/fmc_adc_trigger_unit.sv
// Merges per-channel threshold/hysteresis triggers, delayed external, time and software
// triggers into one registered trigger pulse plus a source mask for the acquisition FSM.
module fmc_adc_trigger_unit #(
    parameter int unsigned g_num_ch    = 4,
    parameter int unsigned g_dly_width = 32
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_n_i,
    fmc_adc_trigger_unit_if.slave  bus
);

    localparam int unsigned C_SMP_W    = 16;
    // Two guard bits so thres +/- hyst can never wrap for any 16-bit input.
    localparam int unsigned C_CMP_W    = C_SMP_W + 2;
    localparam int unsigned C_SRC_W    = g_num_ch + 3;
    localparam int unsigned C_EXT_BIT  = g_num_ch;
    localparam int unsigned C_TIME_BIT = g_num_ch + 1;

    typedef enum logic {CH_DISARMED, CH_ARMED} ch_state_t;
    typedef enum logic {EXT_IDLE, EXT_COUNT} ext_state_t;

    logic [g_num_ch-1:0] w_ch_fire;

    // Per-channel hysteresis trigger with registered fire flag.
    for (genvar gi = 0; gi < g_num_ch; gi++) begin : g_ch
        ch_state_t                   r_state;
        ch_state_t                   w_state_nxt;
        logic                        r_fire;
        logic                        w_fire_nxt;
        logic signed [C_CMP_W-1:0]   w_smp;
        logic signed [C_CMP_W-1:0]   w_thr;
        logic signed [C_CMP_W-1:0]   w_hys;
        logic signed [C_CMP_W-1:0]   w_thr_lo;
        logic signed [C_CMP_W-1:0]   w_thr_hi;
        logic                        w_arm_hit;
        logic                        w_fire_hit;

        assign w_smp    = C_CMP_W'($signed(bus.adc_data_i[C_SMP_W*gi +: C_SMP_W]));
        assign w_thr    = C_CMP_W'($signed(bus.thres_val_i[C_SMP_W*gi +: C_SMP_W]));
        assign w_hys    = C_CMP_W'(bus.thres_hyst_i[C_SMP_W*gi +: C_SMP_W]);
        assign w_thr_lo = w_thr - w_hys;
        assign w_thr_hi = w_thr + w_hys;

        assign w_arm_hit  = bus.ch_pol_i[gi] ? (w_smp > w_thr_hi) : (w_smp < w_thr_lo);
        assign w_fire_hit = bus.ch_pol_i[gi] ? (w_smp < w_thr)    : (w_smp > w_thr);

        always_comb begin
            w_state_nxt = r_state;
            w_fire_nxt  = 1'b0;
            if (bus.adc_valid_i) begin
                case (r_state)
                    CH_DISARMED: begin
                        if (w_arm_hit) begin
                            w_state_nxt = CH_ARMED;
                        end
                    end
                    CH_ARMED: begin
                        if (w_fire_hit) begin
                            w_fire_nxt  = 1'b1;
                            w_state_nxt = CH_DISARMED;
                        end
                    end
                    default: w_state_nxt = CH_DISARMED;
                endcase
            end
        end

        always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
            if (!sys_rst_n_i) begin
                r_state <= CH_DISARMED;
                r_fire  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_fire  <= w_fire_nxt;
            end
        end

        assign w_ch_fire[gi] = r_fire;
    end

    // External trigger: 2-FF synchroniser and edge history.
    logic r_ext_s1;
    logic r_ext_s2;
    logic r_ext_d;
    logic w_ext_edge;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_ext_s1 <= 1'b0;
            r_ext_s2 <= 1'b0;
            r_ext_d  <= 1'b0;
        end else begin
            r_ext_s1 <= bus.ext_trig_i;
            r_ext_s2 <= r_ext_s1;
            r_ext_d  <= r_ext_s2;
        end
    end

    assign w_ext_edge = bus.ext_pol_i ? (~r_ext_s2 & r_ext_d) : (r_ext_s2 & ~r_ext_d);

    ext_state_t              r_ext_state;
    ext_state_t              w_ext_state_nxt;
    logic [g_dly_width-1:0]  r_ext_cnt;
    logic [g_dly_width-1:0]  w_ext_cnt_nxt;
    logic                    w_ext_fire;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_ext_state <= EXT_IDLE;
            r_ext_cnt   <= '0;
        end else begin
            r_ext_state <= w_ext_state_nxt;
            r_ext_cnt   <= w_ext_cnt_nxt;
        end
    end

    // Delay FSM: edges during COUNT are ignored; losing arm aborts without firing.
    always_comb begin
        w_ext_state_nxt = r_ext_state;
        w_ext_cnt_nxt   = r_ext_cnt;
        w_ext_fire      = 1'b0;
        case (r_ext_state)
            EXT_IDLE: begin
                if (w_ext_edge && bus.trig_en_i[C_EXT_BIT] && bus.arm_i) begin
                    w_ext_cnt_nxt   = bus.ext_dly_i;
                    w_ext_state_nxt = EXT_COUNT;
                end
            end
            EXT_COUNT: begin
                if (!bus.arm_i) begin
                    w_ext_state_nxt = EXT_IDLE;
                end else if (r_ext_cnt == '0) begin
                    w_ext_fire      = 1'b1;
                    w_ext_state_nxt = EXT_IDLE;
                end else begin
                    w_ext_cnt_nxt = r_ext_cnt - g_dly_width'(1);
                end
            end
            default: w_ext_state_nxt = EXT_IDLE;
        endcase
    end

    // Combine: software trigger bypasses the enable mask, everything is gated by arm.
    logic [C_SRC_W-1:0] w_src;
    logic               w_trig;
    logic               r_trig;
    logic [C_SRC_W-1:0] r_src;

    assign w_src  = {bus.sw_trig_i,
                     bus.time_trig_i & bus.trig_en_i[C_TIME_BIT],
                     w_ext_fire & bus.trig_en_i[C_EXT_BIT],
                     w_ch_fire & bus.trig_en_i[g_num_ch-1:0]};
    assign w_trig = bus.arm_i & (|w_src);

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_trig <= 1'b0;
            r_src  <= '0;
        end else begin
            r_trig <= w_trig;
            if (w_trig) begin
                r_src <= w_src;
            end
        end
    end

    assign bus.trig_o     = r_trig;
    assign bus.trig_src_o = r_src;

endmodule

// File: tb/tb_fmc_adc_trigger_unit.sv
// Bench for fmc_adc_trigger_unit: table-driven sw/time vectors plus scoreboarded channel,
// external-delay, arm-gating and reset sequences.
module tb_fmc_adc_trigger_unit;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    fmc_adc_trigger_unit_if #(.g_num_ch(NCH), .g_dly_width(DW)) bus ();

    fmc_adc_trigger_unit #(.g_num_ch(NCH), .g_dly_width(DW)) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .bus         (bus)
    );

    typedef struct {
        int unsigned cyc;
        logic [6:0]  src;
    } exp_t;

    typedef struct {
        logic       arm;
        logic [5:0] en;
        logic       tt;
        logic       sw;
        logic       exp_trig;
        logic [6:0] exp_src;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vt[7];
    int          n_chk  = 0;
    int          n_err  = 0;
    int          n_seen = 0;
    int unsigned cyc    = 0;

    // Reference channel model state
    logic       m_armed[NCH];
    int         m_thr = 32'h300;
    int         m_hys[NCH];
    logic [3:0] m_pol = 4'b0100;
    int         tri_v = 0;
    int         tri_dir = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every trig_o pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL missed_trig: no trig_o at cycle %0d, required src=0x%0h", sb[0].cyc, sb[0].src);
                void'(sb.pop_front());
            end
            if (bus.trig_o) begin
                n_seen++;
                n_chk++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_trig: trig_o=1 src=0x%0h at cycle %0d, required no trigger", bus.trig_src_o, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.cyc != cyc || mon_e.src != bus.trig_src_o) begin
                        n_err++;
                        $display("FAIL trig_match: got cycle %0d src=0x%0h, required cycle %0d src=0x%0h",
                                 cyc, bus.trig_src_o, mon_e.cyc, mon_e.src);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_armed[i] = 1'b0;
    endtask

    // Drive one sample on all channels; valid samples update the model and the scoreboard
    task automatic drive_sample(input int v, input logic valid);
        logic [3:0] fire;
        logic [6:0] src;
        int         si;
        tick();
        bus.adc_data_i  = {NCH{16'(v)}};
        bus.adc_valid_i = valid;
        fire = '0;
        if (valid) begin
            si = int'($signed(16'(v)));
            for (int i = 0; i < NCH; i++) begin
                if (!m_armed[i]) begin
                    if (m_pol[i] ? (si > m_thr + m_hys[i]) : (si < m_thr - m_hys[i])) m_armed[i] = 1'b1;
                end else if (m_pol[i] ? (si < m_thr) : (si > m_thr)) begin
                    fire[i]    = 1'b1;
                    m_armed[i] = 1'b0;
                end
            end
            src = {3'b000, fire & bus.trig_en_i[3:0]};
            if (bus.arm_i && src != 7'h00) sb.push_back('{cyc + 2, src});
        end
    endtask

    // Triangle +-0x400 step 8; an invalid garbage sample every 5th cycle
    task automatic run_triangle(input int n_valid);
        for (int k = 0; k < n_valid; k++) begin
            if (k % 4 == 3) drive_sample(-32768, 1'b0);
            drive_sample(tri_v, 1'b1);
            if (tri_v >= 1024) tri_dir = -1;
            else if (tri_v <= -1024) tri_dir = 1;
            tri_v = tri_v + 8 * tri_dir;
        end
        drive_sample(0, 1'b0);
    endtask

    task automatic ramp(input int from, input int to, input int step);
        for (int v = from; (step > 0) ? (v <= to) : (v >= to); v += step) drive_sample(v, 1'b1);
    endtask

    int seen0;

    initial begin
        m_hys = '{256, 256, 128, 256};
        model_reset();
        bus.adc_data_i   = '0;
        bus.adc_valid_i  = 1'b0;
        bus.thres_val_i  = {NCH{16'h0300}};
        bus.thres_hyst_i = {16'h0100, 16'h0080, 16'h0100, 16'h0100};
        bus.ch_pol_i     = m_pol;
        bus.ext_trig_i   = 1'b0;
        bus.ext_pol_i    = 1'b0;
        bus.ext_dly_i    = 32'd3;
        bus.time_trig_i  = 1'b0;
        bus.sw_trig_i    = 1'b0;
        bus.trig_en_i    = '0;
        bus.arm_i        = 1'b0;

        vt[0] = '{1'b0, 6'h3F, 1'b0, 1'b1, 1'b0, 7'h00};
        vt[1] = '{1'b1, 6'h00, 1'b0, 1'b1, 1'b1, 7'h40};
        vt[2] = '{1'b1, 6'h00, 1'b1, 1'b0, 1'b0, 7'h40};
        vt[3] = '{1'b1, 6'h20, 1'b1, 1'b0, 1'b1, 7'h20};
        vt[4] = '{1'b1, 6'h20, 1'b1, 1'b1, 1'b1, 7'h60};
        vt[5] = '{1'b0, 6'h3F, 1'b1, 1'b1, 1'b0, 7'h60};
        vt[6] = '{1'b1, 6'h1F, 1'b1, 1'b0, 1'b0, 7'h60};

        repeat (3) @(posedge clk);
        #1;
        check("rst_trig", 32'(bus.trig_o), 32'h0);
        check("rst_src", 32'(bus.trig_src_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        // Software/time gating, masking, simultaneity and source hold
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.arm_i       = vt[i].arm;
            bus.trig_en_i   = vt[i].en;
            bus.time_trig_i = vt[i].tt;
            bus.sw_trig_i   = vt[i].sw;
            if (vt[i].exp_trig) sb.push_back('{cyc + 1, vt[i].exp_src});
            tick();
            bus.time_trig_i = 1'b0;
            bus.sw_trig_i   = 1'b0;
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_trig", i), 32'(bus.trig_o), 32'(vt[i].exp_trig));
            check($sformatf("vec%0d_src", i), 32'(bus.trig_src_o), 32'(vt[i].exp_src));
        end
        repeat (2) tick();

        // ch1 rising crossings
        bus.arm_i     = 1'b1;
        bus.trig_en_i = 6'h01;
        seen0 = n_seen;
        run_triangle(768);
        repeat (3) tick();
        check("ch1_rise_count", 32'(n_seen - seen0), 32'd2);

        // ch3 falling crossings
        bus.trig_en_i = 6'h04;
        seen0 = n_seen;
        run_triangle(768);
        repeat (3) tick();
        check("ch3_fall_count", 32'(n_seen - seen0), 32'd1);

        // ch3 disabled: hysteresis keeps running, nothing fires
        bus.trig_en_i = 6'h00;
        seen0 = n_seen;
        run_triangle(512);
        repeat (3) tick();
        check("ch3_disabled_count", 32'(n_seen - seen0), 32'd0);

        // External trigger with glitches, dly=3
        bus.trig_en_i = 6'h10;
        bus.ext_dly_i = 32'd3;
        seen0 = n_seen;
        tick();
        sb.push_back('{cyc + 7, 7'h10});
        bus.ext_trig_i = 1'b1; #10;
        bus.ext_trig_i = 1'b0; #2;
        bus.ext_trig_i = 1'b1; #10;
        bus.ext_trig_i = 1'b0; #2;
        bus.ext_trig_i = 1'b1; #10;
        bus.ext_trig_i = 1'b0; #2;
        bus.ext_trig_i = 1'b1; #100;
        bus.ext_trig_i = 1'b0;
        repeat (15) tick();
        check("ext_glitch_count", 32'(n_seen - seen0), 32'd1);

        // Arm dropped during a long external delay
        bus.ext_dly_i = 32'd100;
        seen0 = n_seen;
        tick();
        bus.ext_trig_i = 1'b1;
        repeat (20) tick();
        bus.arm_i = 1'b0;
        repeat (2) tick();
        bus.arm_i = 1'b1;
        repeat (120) tick();
        bus.ext_trig_i = 1'b0;
        repeat (5) tick();
        check("ext_arm_drop_count", 32'(n_seen - seen0), 32'd0);

        // Reset asserted mid COUNT clears outputs at once and drops the pending fire
        bus.trig_en_i = 6'h11;
        tick();
        bus.ext_trig_i = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("src_before_rst", 32'(bus.trig_src_o), 32'h10);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_trig", 32'(bus.trig_o), 32'h0);
        check("midrst_src", 32'(bus.trig_src_o), 32'h0);
        bus.ext_trig_i = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;

        // ch1 must re-arm below thres-hyst before firing again
        seen0 = n_seen;
        ramp(32'h250, 32'h380, 8);
        repeat (3) tick();
        check("no_fire_before_rearm", 32'(n_seen - seen0), 32'd0);
        ramp(32'h380, 32'h1F0, -8);
        ramp(32'h1F0, 32'h380, 8);
        drive_sample(0, 1'b0);
        repeat (30) tick();
        check("rearm_fire_count", 32'(n_seen - seen0), 32'd1);

        repeat (5) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
